// File: rtl/rf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter_pkg
// Purpose  : Shared CPU parameters for the writeback path: datapath width,
//            register index width, writeback requester count and requester
//            IDs. Also provides a small modulo-wrap helper for round-robin
//            index arithmetic.
// Ports    : (package, no ports)
// Revision : 1.0 - initial release
// ============================================================================
package rf_wb_arbiter_pkg;

    localparam int CPU_WORD    = 32;  // datapath width
    localparam int CPU_REG_LOG = 5;   // register index width (32 registers)
    localparam int CPU_NREQ    = 3;   // writeback requesters

    // Writeback requester IDs (slice index on the wb_* buses)
    localparam int REQ_LSU = 0;
    localparam int REQ_MDU = 1;
    localparam int REQ_ALU = 2;

    // Wrap an index known to be in [0, 2*n) back into [0, n).
    function automatic int rr_wrap(input int idx, input int n);
        return (idx >= n) ? (idx - n) : idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : NREQ-way round-robin arbiter. The pointer names the requester
//            with highest priority; search order is ptr, ptr+1, ... mod NREQ.
//            After a grant to i the pointer moves to (i+1) mod NREQ; with no
//            grant it holds.
// Ports    : clk     - clock
//            rst     - synchronous active-high reset (pointer -> 0)
//            req_i   - request vector (already qualified by the caller)
//            grant_o - one-hot grant, combinational from req_i and pointer
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int NREQ = CPU_NREQ
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] grant_o
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Walk the offsets from farthest to nearest so the request closest to
    // the pointer is the last to be written and therefore wins.
    always_comb begin
        int idx;
        grant_o = '0;
        ptr_d   = ptr_q;
        idx     = 0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = rr_wrap(int'(ptr_q) + off, NREQ);
            if (req_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
                ptr_d        = PW'(rr_wrap(idx + 1, NREQ));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Register-file writeback arbiter with scoreboard. Grants one of
//            NREQ writeback requesters per cycle (round-robin), registers the
//            winning rd/data onto the register-file write port one cycle
//            later, and tracks a per-register busy bitmap set by issue-stage
//            allocation and cleared by writeback.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            wb_valid/wb_ready   - per-requester writeback handshake
//            wb_rd/wb_data       - requester i destination/value at slice i
//            alloc_valid/_rd     - issue-stage destination reservation
//            alloc_ready         - reservation accepted (register not busy)
//            rs0/rs1/rs2         - issue-stage source indices
//            src_busy            - bit k set when rsk has a pending write
//            rf_we/rf_rd/rf_wdata- registered register-file write port
//            flush               - pipeline flush, clears all busy bits
//            wb_err              - sticky: writeback to a non-busy register
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int WORD    = CPU_WORD,
    parameter int REG_LOG = CPU_REG_LOG,
    parameter int NREQ    = CPU_NREQ
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         wb_valid,
    output logic [NREQ-1:0]         wb_ready,
    input  logic [NREQ*REG_LOG-1:0] wb_rd,
    input  logic [NREQ*WORD-1:0]    wb_data,
    input  logic                    alloc_valid,
    input  logic [REG_LOG-1:0]      alloc_rd,
    output logic                    alloc_ready,
    input  logic [REG_LOG-1:0]      rs0,
    input  logic [REG_LOG-1:0]      rs1,
    input  logic [REG_LOG-1:0]      rs2,
    output logic [2:0]              src_busy,
    output logic                    rf_we,
    output logic [REG_LOG-1:0]      rf_rd,
    output logic [WORD-1:0]         rf_wdata,
    input  logic                    flush,
    output logic                    wb_err
);

    localparam int NREG = 1 << REG_LOG;

    logic [NREG-1:0]    busy_q;
    logic [NREG-1:0]    busy_d;
    logic               rf_we_q;
    logic [REG_LOG-1:0] rf_rd_q;
    logic [WORD-1:0]    rf_wdata_q;
    logic               wb_err_q;
    logic               wb_err_d;

    logic [NREQ-1:0]    req_gated;
    logic [NREQ-1:0]    grant;
    logic [REG_LOG-1:0] sel_rd;
    logic [WORD-1:0]    sel_data;
    logic               handshake;
    logic               wr_en;
    logic               alloc_set;

    // No grant can be issued while in reset or during a flush cycle; gating
    // the requests also keeps the round-robin pointer still in those cycles.
    assign req_gated = (rst || flush) ? '0 : wb_valid;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req_i   (req_gated),
        .grant_o (grant)
    );

    // A grant is only produced for a valid requester, so ready == grant
    // already implies valid && ready.
    assign wb_ready  = grant;
    assign handshake = |grant;

    // One-hot grant makes an OR-mux sufficient.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_rd   = sel_rd   | wb_rd[i*REG_LOG +: REG_LOG];
                sel_data = sel_data | wb_data[i*WORD +: WORD];
            end
        end
    end

    // r0 is hardwired: its grants are consumed but never written or tracked.
    assign wr_en = handshake && (sel_rd != '0);

    assign alloc_ready = !rst && !flush
                       && ((alloc_rd == '0) || !busy_q[alloc_rd]);
    assign alloc_set   = alloc_valid && alloc_ready && (alloc_rd != '0);

    // A register being allocated is never busy, so it cannot also be the
    // register being cleared this cycle; both updates can apply together.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[sel_rd] = 1'b0;
        end
        if (alloc_set) begin
            busy_d[alloc_rd] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
    end

    assign wb_err_d = wb_err_q || (wr_en && !busy_q[sel_rd]);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            rf_we_q  <= wr_en;
            wb_err_q <= wb_err_d;
            if (wr_en) begin
                rf_rd_q    <= sel_rd;
                rf_wdata_q <= sel_data;
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;
    assign wb_err   = wb_err_q;

    // busy_q[0] is never set, but the explicit r0 test keeps intent obvious.
    assign src_busy[0] = (rs0 != '0) && busy_q[rs0];
    assign src_busy[1] = (rs1 != '0) && busy_q[rs1];
    assign src_busy[2] = (rs2 != '0) && busy_q[rs2];

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Purpose  : Self-checking testbench for rf_wb_arbiter. Expected register-
//            file writes are queued when a writeback is driven and compared
//            in order when rf_we is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;
    import rf_wb_arbiter_pkg::*;

    localparam int WORD    = 32;
    localparam int REG_LOG = 5;
    localparam int NREQ    = 3;

    logic                    clk;
    logic                    rst;
    logic [NREQ-1:0]         wb_valid;
    logic [NREQ-1:0]         wb_ready;
    logic [NREQ*REG_LOG-1:0] wb_rd;
    logic [NREQ*WORD-1:0]    wb_data;
    logic                    alloc_valid;
    logic [REG_LOG-1:0]      alloc_rd;
    logic                    alloc_ready;
    logic [REG_LOG-1:0]      rs0, rs1, rs2;
    logic [2:0]              src_busy;
    logic                    rf_we;
    logic [REG_LOG-1:0]      rf_rd;
    logic [WORD-1:0]         rf_wdata;
    logic                    flush;
    logic                    wb_err;

    rf_wb_arbiter #(
        .WORD    (WORD),
        .REG_LOG (REG_LOG),
        .NREQ    (NREQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .alloc_ready (alloc_ready),
        .rs0         (rs0),
        .rs1         (rs1),
        .rs2         (rs2),
        .src_busy    (src_busy),
        .rf_we       (rf_we),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata),
        .flush       (flush),
        .wb_err      (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [REG_LOG-1:0] rd;
        logic [WORD-1:0]    data;
    } wr_t;

    wr_t exp_q[$];

    // Scoreboard: every observed register-file write must match the oldest
    // expected write.
    always @(negedge clk) begin : mon
        wr_t e;
        if (rf_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rf_write_unexpected: got rd=%0d data=%h, required no write", rf_rd, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                if (rf_rd !== e.rd || rf_wdata !== e.data) begin
                    n_bad++;
                    $display("FAIL rf_write: got rd=%0d data=%h, required rd=%0d data=%h", rf_rd, rf_wdata, e.rd, e.data);
                end
            end
        end
    end

    task automatic set_wb(input int i, input logic [REG_LOG-1:0] rd, input logic [WORD-1:0] d);
        wb_valid[i]                 = 1'b1;
        wb_rd[i*REG_LOG +: REG_LOG] = rd;
        wb_data[i*WORD +: WORD]     = d;
    endtask

    task automatic push_exp(input logic [REG_LOG-1:0] rd, input logic [WORD-1:0] d);
        wr_t e;
        e.rd   = rd;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One-cycle reservation of rd; returns at the negedge after the capture.
    task automatic do_alloc(input logic [REG_LOG-1:0] rd);
        @(negedge clk);
        alloc_valid = 1'b1;
        alloc_rd    = rd;
        @(negedge clk);
        alloc_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; wb_valid = '1; wb_rd = '0; wb_data = '0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (wb_ready !== 3'b000) begin n_bad++; $display("FAIL reset_wb_ready: got %b, required 000", wb_ready); end
        n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL reset_alloc_ready: got %b, required 0", alloc_ready); end
        @(negedge clk);
        rst = 1'b0; wb_valid = '0; rs0 = 5'd5; rs1 = 5'd1; rs2 = 5'd31;
        #1;
        n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL idle_rf_we: got %b, required 0", rf_we); end
        n_cmp++; if (src_busy !== 3'b000) begin n_bad++; $display("FAIL idle_src_busy: got %b, required 000", src_busy); end
        n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL idle_alloc_ready: got %b, required 1", alloc_ready); end
        n_cmp++; if (wb_err !== 1'b0) begin n_bad++; $display("FAIL idle_wb_err: got %b, required 0", wb_err); end
    endtask

    task automatic test_alu_write;
        do_alloc(5'd5);
        rs0 = 5'd5;
        #1;
        n_cmp++; if (src_busy !== 3'b001) begin n_bad++; $display("FAIL alu_busy_after_alloc: got %b, required 001", src_busy); end
        set_wb(REQ_ALU, 5'd5, 32'h0000_1234);
        #1;
        n_cmp++; if (wb_ready !== 3'b100) begin n_bad++; $display("FAIL alu_grant: got %b, required 100", wb_ready); end
        push_exp(5'd5, 32'h0000_1234);
        @(negedge clk);
        wb_valid = '0;
        #1;
        n_cmp++; if (src_busy !== 3'b000) begin n_bad++; $display("FAIL alu_busy_cleared: got %b, required 000", src_busy); end
    endtask

    task automatic test_round_robin;
        logic [WORD-1:0] dat [3];
        dat[0] = 32'hA000_0001; dat[1] = 32'hB000_0002; dat[2] = 32'hC000_0003;
        do_alloc(5'd1); do_alloc(5'd2); do_alloc(5'd3);
        rs0 = 5'd1; rs1 = 5'd2; rs2 = 5'd3;
        #1;
        n_cmp++; if (src_busy !== 3'b111) begin n_bad++; $display("FAIL rr_busy: got %b, required 111", src_busy); end
        for (int k = 0; k < 3; k++) set_wb(k, REG_LOG'(k + 1), dat[k]);
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++;
            if (wb_ready !== (3'b001 << k)) begin
                n_bad++; $display("FAIL rr_grant_%0d: got %b, required %b", k, wb_ready, 3'b001 << k);
            end
            push_exp(REG_LOG'(k + 1), dat[k]);
            @(negedge clk);
            wb_valid[k] = 1'b0;
        end
        #1;
        n_cmp++; if (src_busy !== 3'b000) begin n_bad++; $display("FAIL rr_busy_cleared: got %b, required 000", src_busy); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        alloc_valid = 1'b1; alloc_rd = 5'd7;
        #1;
        n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_first_alloc: got %b, required 1", alloc_ready); end
        @(negedge clk);
        #1;
        n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_second_blocked: got %b, required 0", alloc_ready); end
        repeat (2) @(negedge clk);
        set_wb(REQ_MDU, 5'd7, 32'h0000_BEEF);
        #1;
        n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_still_blocked: got %b, required 0", alloc_ready); end
        n_cmp++; if (wb_ready !== 3'b010) begin n_bad++; $display("FAIL b2b_mdu_grant: got %b, required 010", wb_ready); end
        push_exp(5'd7, 32'h0000_BEEF);
        @(negedge clk);
        wb_valid = '0;
        #1;
        n_cmp++; if (alloc_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_after_wb: got %b, required 1", alloc_ready); end
        @(negedge clk);
        alloc_valid = 1'b0;
    endtask

    task automatic test_r0_and_err;
        @(negedge clk);
        set_wb(REQ_LSU, 5'd0, 32'hFFFF_FFFF);
        #1;
        n_cmp++; if (wb_ready !== 3'b001) begin n_bad++; $display("FAIL r0_grant: got %b, required 001", wb_ready); end
        @(negedge clk);
        wb_valid = '0;
        #1;
        n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL r0_no_write: got %b, required 0", rf_we); end
        n_cmp++; if (wb_err !== 1'b0) begin n_bad++; $display("FAIL err_before: got %b, required 0", wb_err); end
        set_wb(REQ_ALU, 5'd9, 32'h0000_0099);
        #1;
        n_cmp++; if (wb_ready !== 3'b100) begin n_bad++; $display("FAIL r9_grant: got %b, required 100", wb_ready); end
        push_exp(5'd9, 32'h0000_0099);
        @(negedge clk);
        wb_valid = '0;
        #1;
        n_cmp++; if (wb_err !== 1'b1) begin n_bad++; $display("FAIL err_set: got %b, required 1", wb_err); end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (wb_err !== 1'b1) begin n_bad++; $display("FAIL err_held: got %b, required 1", wb_err); end
    endtask

    task automatic test_flush;
        do_alloc(5'd4); do_alloc(5'd6);
        rs0 = 5'd4; rs1 = 5'd6; rs2 = 5'd7;
        #1;
        n_cmp++; if (src_busy !== 3'b111) begin n_bad++; $display("FAIL flush_busy_before: got %b, required 111", src_busy); end
        set_wb(REQ_ALU, 5'd4, 32'h0000_4444);
        #1;
        n_cmp++; if (wb_ready !== 3'b100) begin n_bad++; $display("FAIL flush_pre_grant: got %b, required 100", wb_ready); end
        push_exp(5'd4, 32'h0000_4444);
        @(negedge clk);
        wb_valid = '0; flush = 1'b1;
        set_wb(REQ_LSU, 5'd6, 32'h0000_6666);
        alloc_valid = 1'b1; alloc_rd = 5'd10;
        #1;
        n_cmp++; if (wb_ready !== 3'b000) begin n_bad++; $display("FAIL flush_wb_ready: got %b, required 000", wb_ready); end
        n_cmp++; if (alloc_ready !== 1'b0) begin n_bad++; $display("FAIL flush_alloc_ready: got %b, required 0", alloc_ready); end
        n_cmp++; if (src_busy !== 3'b110) begin n_bad++; $display("FAIL flush_cycle_busy: got %b, required 110", src_busy); end
        @(negedge clk);
        flush = 1'b0; wb_valid = '0; alloc_valid = 1'b0; rs0 = 5'd10;
        #1;
        n_cmp++; if (src_busy !== 3'b000) begin n_bad++; $display("FAIL flush_busy_cleared: got %b, required 000", src_busy); end
        n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL flush_no_write: got %b, required 0", rf_we); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        set_wb(REQ_LSU, 5'd0, 32'h0);
        #1;
        n_cmp++; if (wb_ready !== 3'b001) begin n_bad++; $display("FAIL mid_pre_grant: got %b, required 001", wb_ready); end
        @(negedge clk);
        wb_valid = '0;
        do_alloc(5'd12);
        rs0 = 5'd12;
        #1;
        n_cmp++; if (src_busy !== 3'b001) begin n_bad++; $display("FAIL mid_busy: got %b, required 001", src_busy); end
        @(negedge clk);
        rst = 1'b1;
        set_wb(REQ_ALU, 5'd12, 32'h0000_00CC);
        alloc_valid = 1'b1; alloc_rd = 5'd13;
        #1;
        n_cmp++; if (wb_ready !== 3'b000) begin n_bad++; $display("FAIL mid_wb_ready: got %b, required 000", wb_ready); end
        @(negedge clk);
        rst = 1'b0; wb_valid = '0; alloc_valid = 1'b0; rs1 = 5'd13;
        #1;
        n_cmp++; if (rf_we !== 1'b0) begin n_bad++; $display("FAIL mid_rf_we: got %b, required 0", rf_we); end
        n_cmp++; if (wb_err !== 1'b0) begin n_bad++; $display("FAIL mid_err_cleared: got %b, required 0", wb_err); end
        n_cmp++; if (src_busy !== 3'b000) begin n_bad++; $display("FAIL mid_busy_cleared: got %b, required 000", src_busy); end
        for (int k = 0; k < 3; k++) set_wb(k, 5'd0, 32'h0);
        #1;
        n_cmp++; if (wb_ready !== 3'b001) begin n_bad++; $display("FAIL mid_ptr_reset: got %b, required 001", wb_ready); end
        @(negedge clk);
        wb_valid = '0;
    endtask

    initial begin
        rst = 1'b1; wb_valid = '0; wb_rd = '0; wb_data = '0;
        alloc_valid = 1'b0; alloc_rd = '0; flush = 1'b0;
        rs0 = '0; rs1 = '0; rs2 = '0;
        test_reset();
        test_alu_write();
        test_round_robin();
        test_back_to_back();
        test_r0_and_err();
        test_flush();
        test_reset_mid();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++; $display("FAIL pending_writes: got %0d outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter WORD, default 32, meaning datapath width.
REQ-002 SHALL have parameter REG_LOG, default 5, meaning register index width (32 registers).
REQ-003 SHALL have parameter NREQ, default 3, meaning writeback requesters (0=LSU, 1=MDU, 2=ALU).
REQ-004 SHALL have port clk  input  1  clock; posedge-sampled.
REQ-005 SHALL have port rst  input  1  reset; reset rst, synchronous, active-high.
REQ-006 SHALL have ports wb_valid/wb_ready  input/output  NREQ each  per-requester writeback handshake.
REQ-007 SHALL have ports wb_rd/wb_data  input  NREQ*REG_LOG / NREQ*WORD  destination and value, requester i at slice i.
REQ-008 SHALL have ports alloc_valid/alloc_rd/alloc_ready  input/input/output  1/REG_LOG/1  issue-stage destination reservation.
REQ-009 SHALL have ports rs0/rs1/rs2  input  REG_LOG each  issue-stage source indices.
REQ-010 SHALL have port src_busy  output  3  bit k set when rsk has a pending write.
REQ-011 SHALL have ports rf_we/rf_rd/rf_wdata  output  1/REG_LOG/WORD  drive register-file write port (written there on negedge).
REQ-012 SHALL have port flush  input  1  pipeline flush.
REQ-013 SHALL have port wb_err  output  1  sticky error: writeback to non-busy register.

Function
REQ-014 SHALL grant at most one requester per cycle; wb_ready[i] combinational, = grant[i]; handshake = valid&&ready.
REQ-015 SHALL arbitrate round-robin: pointer p = highest priority, search p, p+1, ... mod NREQ; after grant to i, p <= (i+1) mod NREQ; p unchanged when no grant.
REQ-016 SHALL register the granted rd/data into rf_rd/rf_wdata with rf_we=1 on the following cycle (latency 1); rf_we=0 in cycles without a prior grant.
REQ-017 SHALL hold a 32-bit busy bitmap; handshake with rd!=0 clears busy[rd] at the same edge that loads the output register.
REQ-018 SHALL force rf_we=0 for rd=0 grants; grant still consumes the request and advances p.
REQ-019 SHALL assert alloc_ready = ~busy[alloc_rd] (always 1 for rd=0); alloc_valid&&alloc_ready sets busy[alloc_rd] for rd!=0.
REQ-020 SHALL drive src_busy[k] = busy[rsk] combinationally, rsk=0 always 0.
REQ-021 SHALL set wb_err on a granted write whose rd!=0 has busy[rd]=0; wb_err clears only on rst.
REQ-022 SHALL, on flush, clear all busy bits, deassert all wb_ready and alloc_ready that cycle, and leave an already-registered rf_we write to complete.
REQ-023 SHALL never let alloc and writeback of the same register collide (guaranteed by REQ-019); alloc and clear of different registers in one cycle both take effect.

Reset
REQ-024 SHALL on rst: busy=0, p=0, rf_we=0, rf_rd=0, rf_wdata=0, wb_err=0; wb_ready and alloc_ready 0 while rst high.
REQ-025 SHALL discard any pending grant or output write when rst asserts mid-operation.

Structure
REQ-026 SHALL take WORD and REG_LOG from the shared CPU parameter header; requester IDs (LSU/MDU/ALU) defined there as constants.
REQ-027 SHALL implement arbitration in one sub-module rr_arbiter (NREQ-way round-robin, request in, one-hot grant out, pointer register).

Verification
REQ-028 Reset then idle -> rf_we=0, all src_busy=0, alloc_ready=1.
REQ-029 alloc r5; ALU wb r5=0x1234 -> next cycle rf_we=1, rf_rd=5, rf_wdata=0x1234; src_busy for rs0=5 drops same cycle.
REQ-030 alloc r1,r2,r3; all three valid continuously from p=0 -> grants LSU, MDU, ALU in consecutive cycles.
REQ-031 alloc r7 twice back-to-back -> second alloc_ready=0 until r7 written back.
REQ-032 wb to r0 = 0xFFFF_FFFF -> wb_ready=1, rf_we stays 0; wb to non-busy r9 -> wb_err=1 and held.
REQ-033 busy r4,r6 then flush -> src_busy clears next cycle, no grants during flush cycle.
